out_display: RTL

OUT_DISPLAY -- requirements
Module: out_display

---
 rtl/out_display_if.sv | 11 +
 rtl/out_display.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/out_display_if.sv
// OUT-instruction capture bus between the processor and the display block.
interface out_display_if;
    logic        out_en;
    logic [2:0]  outsel;
    logic [15:0] outval1;
    logic [15:0] outval2;
    logic        ready;

    modport master (output out_en, outsel, outval1, outval2, input ready);
    modport slave  (input out_en, outsel, outval1, outval2, output ready);
endinterface

// File: rtl/out_display.sv
// Buffers OUT values in a 4-deep FIFO and shows each on a multiplexed 4-digit hex display.
// Define OUT_DISPLAY_PENDING_DP_EN to light the digit-0 decimal point while entries are pending.
module out_display #(
    parameter int HOLD_CYCLES = 1000000,
    parameter int SCAN_DIV    = 1024
) (
    input  logic           clock,
    input  logic           reset,
    out_display_if.slave   bus,
    output logic [7:0]     seg_n,
    output logic [3:0]     an_n,
    output logic [2:0]     led,
    output logic           ovf
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

    entry_t          mem [4];
    entry_t          disp;
    logic [1:0]      wp, rp;
    logic [2:0]      count;
    logic            push, pop, nonempty;
    state_t          state, state_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [SW-1:0]   scan_cnt;
    logic [1:0]      digit;

    assign bus.ready = (count < 3'd4);
    assign push      = bus.out_en & bus.ready;
    assign nonempty  = (count != 3'd0);

    // Storage carries no reset; validity is tracked solely by the pointers and count.
    always_ff @(posedge clock) begin
        if (push)
            mem[wp] <= '{sel: bus.outsel, data: (bus.outsel[0] ? bus.outval2 : bus.outval1)};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wp <= wp + 2'd1;
            if (pop)  rp <= rp + 2'd1;
            count <= count + 3'(push) - 3'(pop);
            if (bus.out_en && !bus.ready) ovf <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                hold_n = '0;
                if (nonempty) begin
                    pop     = 1'b1;
                    state_n = SHOW;
                end
            end
            SHOW: begin
                if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    hold_n = '0;
                    if (nonempty) pop = 1'b1;
                    else          state_n = HOLD;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            HOLD: begin
                hold_n = '0;
                if (nonempty) begin
                    pop     = 1'b1;
                    state_n = SHOW;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            disp     <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            if (pop) disp <= mem[rp];
        end
    end

    // Digit scan runs continuously so the refresh phase is independent of traffic.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            digit    <= digit + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] glyph_n(input logic [3:0] n);
        case (n)
            4'h0: return ~7'h3F;
            4'h1: return ~7'h06;
            4'h2: return ~7'h5B;
            4'h3: return ~7'h4F;
            4'h4: return ~7'h66;
            4'h5: return ~7'h6D;
            4'h6: return ~7'h7D;
            4'h7: return ~7'h07;
            4'h8: return ~7'h7F;
            4'h9: return ~7'h6F;
            4'hA: return ~7'h77;
            4'hB: return ~7'h7C;
            4'hC: return ~7'h39;
            4'hD: return ~7'h5E;
            4'hE: return ~7'h79;
            default: return ~7'h71;
        endcase
    endfunction

    logic       active, dp_n;
    logic [3:0] nib;

    assign active = (state != IDLE);

    always_comb begin
        case (digit)
            2'd0:    nib = disp.data[3:0];
            2'd1:    nib = disp.data[7:4];
            2'd2:    nib = disp.data[11:8];
            default: nib = disp.data[15:12];
        endcase
    end

`ifdef OUT_DISPLAY_PENDING_DP_EN
    assign dp_n = ~(active && (digit == 2'd0) && nonempty);
`else
    assign dp_n = 1'b1;
`endif

    assign seg_n = active ? {dp_n, glyph_n(nib)} : 8'hFF;
    assign an_n  = active ? ~(4'b0001 << digit) : 4'hF;
    assign led   = active ? disp.sel : 3'd0;
endmodule
